register_bank_sb: RTL and testbench
===================================

// Module: register_bank_sb
// PURPOSE
//  Parametrised successor to the single-cycle register bank; intended for the pipelined core.
//  - Two combinational read ports with optional same-cycle write bypass.
//  - Independent writeback and link (jal) write ports.
//  - Per-register busy scoreboard so hazard logic can stall on pending producers.
//  - Register 0 hardwired to zero.
// PARAMETERS
//  DATA_W       32  register width in bits
//  NUM_REGS     32  number of registers (power of 2, >=4)
//  ADDR_W       5   $clog2(NUM_REGS)
//  LINK_REG     31  destination register of link writes
//  LINK_OFFSET  1   added to link_pc (word-addressed PC)
//  BYPASS       1   1: reads see a same-cycle write; 0: reads see stored value only
// PORTS
//  clock       in   1       rising-edge clock
//  reset_n     in   1       asynchronous active-low reset
//  rd_addr_a   in   ADDR_W  read port A address
//  rd_addr_b   in   ADDR_W  read port B address
//  rd_data_a   out  DATA_W  read port A data (signed)
//  rd_data_b   out  DATA_W  read port B data (signed)
//  rd_busy_a   out  1       register at rd_addr_a has a pending producer
//  rd_busy_b   out  1       register at rd_addr_b has a pending producer
//  wr_en       in   1       writeback enable
//  wr_addr     in   ADDR_W  writeback destination
//  wr_data     in   DATA_W  writeback data (signed)
//  link_en     in   1       link write enable (jal)
//  link_pc     in   DATA_W  PC of the jal instruction
//  issue_en    in   1       instruction with a destination issued this cycle
//  issue_addr  in   ADDR_W  destination of the issued instruction
//  busy_vec    out  NUM_REGS  busy bit per register, registered
// BEHAVIOUR
//  - Reset (reset_n low, async): all registers 0, all busy bits 0. Outputs follow immediately:
//    rd_data_* 0, rd_busy_* 0, busy_vec 0. Deassertion is synchronised externally.
//  - Register 0: reads 0, writes dropped, busy bit never set. Holds for all ports.
//  - Writes commit on rising clock. link_en writes link_pc+LINK_OFFSET (mod 2^DATA_W) to LINK_REG.
//  - wr_en and link_en are independent:
//    - Both active, different addresses: both commit.
//    - wr_addr==LINK_REG: link value wins.
//  - Reads are combinational, 0-cycle latency. Priority when BYPASS=1 and rd_addr!=0:
//    1. link value if link_en and rd_addr==LINK_REG
//    2. else wr_data if wr_en and wr_addr==rd_addr
//    3. else stored value
//    With BYPASS=0, reads return the stored value; new data is visible the cycle after the write.
//  - Scoreboard, next-state per register r!=0:
//    - set: issue_en && issue_addr==r
//    - clear: (wr_en && wr_addr==r) || (link_en && r==LINK_REG)
//    - set and clear in the same cycle on the same r: set wins (a newer producer is outstanding).
//    - Issue to r0 is ignored.
//  - rd_busy_x = busy[rd_addr_x] && !(BYPASS && clear condition for rd_addr_x this cycle).
//    The same-cycle issue does not raise rd_busy (registered; visible next cycle).
//  - Writes to a register that is not busy are legal and commit normally.
//  - Reset mid-operation: pending busy bits are discarded and no in-flight write commits.
// STRUCTURE
//  - Shared package core_pkg: DATA_W, REG_ADDR_W, REG_ZERO, REG_RA (31),
//    typedef reg_addr_t, typedef word_t.
//  - Sub-module rb_read_port: one combinational read mux with bypass priority and busy qualify,
//    instantiated twice.
//  - Storage and scoreboard stay in the top module.
// TESTING
//  1. Reset: write x5=0x1234, pulse reset_n low mid-cycle -> rd_data_a(x5)=0 immediately,
//     busy_vec=0.
//  2. r0: wr_en addr0 data 0xFFFF_FFFF, issue_en addr0 -> rd_data(x0)=0, busy_vec[0]=0.
//  3. Bypass: wr_en x7=0xDEAD_BEEF, rd_addr_a=7 same cycle -> rd_data_a=0xDEAD_BEEF
//     with BYPASS=1; old value with BYPASS=0, new value next cycle.
//  4. Link collision: wr_en x31=0x55, link_en link_pc=0x100 same cycle ->
//     x31=0x101, rd_data_b(x31)=0x101 that cycle.
//  5. Scoreboard: issue x9 -> busy_vec[9]=1 next cycle; later wr_en x9 with issue_en x9
//     same cycle -> busy stays 1; wr_en x9 alone -> rd_busy_a(9)=0 that cycle, bit 0 next.
//  6. Link wrap: link_pc=0xFFFF_FFFF -> x31=0x0000_0000.

Source files
------------

// File: rtl/core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | core_pkg                                                         |
// | Shared core-wide widths, register-file indices and types.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package core_pkg;
  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  localparam reg_addr_t REG_ZERO = 5'd0;
  localparam reg_addr_t REG_RA   = 5'd31;
endpackage
`default_nettype wire

// File: rtl/rb_read_port.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rb_read_port                                                     |
// | One combinational register-file read mux with write bypass and   |
// | busy qualification.                                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rb_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        stored_data,
  input  logic                     stored_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_data,
  output logic signed [DATA_W-1:0] rd_data,
  output logic                     rd_busy
);
  import core_pkg::*;

  localparam logic [ADDR_W-1:0] c_link_addr = ADDR_W'(LINK_REG);
  localparam logic              c_bypass    = (BYPASS != 0);

  logic w_hit_link;
  logic w_hit_wr;
  logic w_nonzero;

  assign w_hit_link = link_en && (rd_addr == c_link_addr);
  assign w_hit_wr   = wr_en && (wr_addr == rd_addr);
  assign w_nonzero  = (rd_addr != '0);

  // Link beats writeback, mirroring the storage commit order.
  always_comb begin
    rd_data = '0;
    if (w_nonzero) begin
      if (c_bypass && w_hit_link)    rd_data = link_data;
      else if (c_bypass && w_hit_wr) rd_data = wr_data;
      else                           rd_data = stored_data;
    end
  end

  assign rd_busy = stored_busy && !(c_bypass && (w_hit_link || w_hit_wr));
endmodule
`default_nettype wire

// File: rtl/register_bank_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | register_bank_sb                                                 |
// | Pipelined-core register bank: two bypassed read ports, writeback |
// | and link write ports, per-register busy scoreboard.              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module register_bank_sb #(
  parameter int DATA_W      = core_pkg::DATA_W,
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int LINK_REG    = int'(core_pkg::REG_RA),
  parameter int LINK_OFFSET = 1,
  parameter int BYPASS      = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        rd_addr_a,
  input  logic [ADDR_W-1:0]        rd_addr_b,
  output logic signed [DATA_W-1:0] rd_data_a,
  output logic signed [DATA_W-1:0] rd_data_b,
  output logic                     rd_busy_a,
  output logic                     rd_busy_b,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     link_en,
  input  logic [DATA_W-1:0]        link_pc,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);
  import core_pkg::*;

  localparam logic [ADDR_W-1:0] c_link_addr = ADDR_W'(LINK_REG);
  localparam logic [DATA_W-1:0] c_link_off  = DATA_W'(LINK_OFFSET);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [DATA_W-1:0]   w_link_val;

  assign w_link_val = link_pc + c_link_off;

  // Link is assigned last so it overrides a writeback to the same register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (wr_en && (wr_addr != '0)) r_regs[wr_addr] <= wr_data;
      if (link_en && (c_link_addr != '0)) r_regs[c_link_addr] <= w_link_val;
    end
  end

  // Set after clear: a newly issued producer outlives the retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < NUM_REGS; i++) begin
      if ((wr_en && (wr_addr == ADDR_W'(i))) || (link_en && (c_link_addr == ADDR_W'(i))))
        w_busy_nxt[i] = 1'b0;
      if (issue_en && (issue_addr == ADDR_W'(i)))
        w_busy_nxt[i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  assign busy_vec = r_busy;

  rb_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK_REG), .BYPASS(BYPASS)
  ) u_port_a (
    .rd_addr(rd_addr_a), .stored_data(r_regs[rd_addr_a]), .stored_busy(r_busy[rd_addr_a]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(w_link_val),
    .rd_data(rd_data_a), .rd_busy(rd_busy_a)
  );

  rb_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINK_REG(LINK_REG), .BYPASS(BYPASS)
  ) u_port_b (
    .rd_addr(rd_addr_b), .stored_data(r_regs[rd_addr_b]), .stored_busy(r_busy[rd_addr_b]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_data(w_link_val),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b)
  );
endmodule
`default_nettype wire

// File: tb/tb_register_bank_sb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_register_bank_sb                                              |
// | Directed vector bench for register_bank_sb (BYPASS=1 and 0).     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_register_bank_sb;
  logic        clock;
  logic        reset_n;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr, issue_addr;
  logic [31:0] wr_data, link_pc;
  logic        wr_en, link_en, issue_en;

  logic signed [31:0] da, db, da0, db0;
  logic               ba, bb, ba0, bb0;
  logic [31:0]        bv, bv0;

  int n_tests = 0;
  int n_fail  = 0;

  register_bank_sb #(.BYPASS(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da), .rd_data_b(db), .rd_busy_a(ba), .rd_busy_b(bb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_pc(link_pc),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(bv)
  );

  register_bank_sb #(.BYPASS(0)) dut_nb (
    .clock(clock), .reset_n(reset_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(da0), .rd_data_b(db0), .rd_busy_a(ba0), .rd_busy_b(bb0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .link_en(link_en), .link_pc(link_pc),
    .issue_en(issue_en), .issue_addr(issue_addr), .busy_vec(bv0)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        we;  logic [4:0] wa; logic [31:0] wd;
    logic        le;  logic [31:0] lpc;
    logic        ie;  logic [4:0] ia;
    logic [4:0]  ra;  logic [4:0] rb;
    logic [31:0] e_da; logic [31:0] e_db;
    logic        e_ba; logic e_bb;
    logic [31:0] e_bv;
    logic [31:0] e_da0;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_addr = 0; wr_data = 0;
    link_en = 0; link_pc = 0; issue_en = 0; issue_addr = 0;
    rd_addr_a = 0; rd_addr_b = 0;
  endtask

  initial begin
    //           we wa     wd            le lpc           ie ia     ra     rb     e_da          e_db          ba bb e_bv          e_da0
    vecs[0]  = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 32'h0,        32'h0};
    vecs[1]  = '{1, 5'd7,  32'hDEADBEEF, 0, 32'h0,        0, 5'd0,  5'd7,  5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0};
    vecs[2]  = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd7,  5'd0,  32'hDEADBEEF, 32'h0,        0, 0, 32'h0,        32'hDEADBEEF};
    vecs[3]  = '{1, 5'd0,  32'hFFFFFFFF, 0, 32'h0,        1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 32'h0,        32'h0};
    vecs[4]  = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        0, 0, 32'h0,        32'h0};
    vecs[5]  = '{1, 5'd31, 32'h55,       1, 32'h100,      0, 5'd0,  5'd31, 5'd31, 32'h101,      32'h101,      0, 0, 32'h0,        32'h0};
    vecs[6]  = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd31, 5'd31, 32'h101,      32'h101,      0, 0, 32'h0,        32'h101};
    vecs[7]  = '{0, 5'd0,  32'h0,        0, 32'h0,        1, 5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        0, 0, 32'h0,        32'h0};
    vecs[8]  = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd9,  5'd9,  32'h0,        32'h0,        1, 1, 32'h200,      32'h0};
    vecs[9]  = '{1, 5'd9,  32'h99,       0, 32'h0,        1, 5'd9,  5'd9,  5'd0,  32'h99,       32'h0,        0, 0, 32'h200,      32'h0};
    vecs[10] = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd9,  5'd0,  32'h99,       32'h0,        1, 0, 32'h200,      32'h99};
    vecs[11] = '{1, 5'd9,  32'h77,       0, 32'h0,        0, 5'd0,  5'd9,  5'd9,  32'h77,       32'h77,       0, 0, 32'h200,      32'h99};
    vecs[12] = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd9,  5'd0,  32'h77,       32'h0,        0, 0, 32'h0,        32'h77};
    vecs[13] = '{0, 5'd0,  32'h0,        1, 32'hFFFFFFFF, 0, 5'd0,  5'd31, 5'd0,  32'h0,        32'h0,        0, 0, 32'h0,        32'h101};
    vecs[14] = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd31, 5'd7,  32'h0,        32'hDEADBEEF, 0, 0, 32'h0,        32'h0};
    vecs[15] = '{0, 5'd0,  32'h0,        0, 32'h0,        1, 5'd31, 5'd5,  5'd0,  32'h0,        32'h0,        0, 0, 32'h0,        32'h0};
    vecs[16] = '{0, 5'd0,  32'h0,        1, 32'h20,       0, 5'd0,  5'd31, 5'd31, 32'h21,       32'h21,       0, 0, 32'h80000000, 32'h0};
    vecs[17] = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd31, 5'd31, 32'h21,       32'h21,       0, 0, 32'h0,        32'h21};
    vecs[18] = '{1, 5'd3,  32'h33,       1, 32'h40,       0, 5'd0,  5'd3,  5'd31, 32'h33,       32'h41,       0, 0, 32'h0,        32'h0};
    vecs[19] = '{0, 5'd0,  32'h0,        0, 32'h0,        0, 5'd0,  5'd3,  5'd31, 32'h33,       32'h41,       0, 0, 32'h0,        32'h33};

    idle();
    reset_n = 1'b0;
    #2;
    chk("reset rd_data_a", -1, da, 32'h0);
    chk("reset busy_vec", -1, bv, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      link_en = vecs[i].le; link_pc = vecs[i].lpc;
      issue_en = vecs[i].ie; issue_addr = vecs[i].ia;
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      #2;
      chk("rd_data_a", i, da, vecs[i].e_da);
      chk("rd_data_b", i, db, vecs[i].e_db);
      chk("rd_busy_a", i, {31'b0, ba}, {31'b0, vecs[i].e_ba});
      chk("rd_busy_b", i, {31'b0, bb}, {31'b0, vecs[i].e_bb});
      chk("busy_vec", i, bv, vecs[i].e_bv);
      chk("nobypass rd_data_a", i, da0, vecs[i].e_da0);
    end

    // Mid-cycle asynchronous reset discards stored data and busy bits.
    @(negedge clock);
    idle();
    wr_en = 1; wr_addr = 5; wr_data = 32'h1234;
    issue_en = 1; issue_addr = 5;
    @(negedge clock);
    idle();
    rd_addr_a = 5; rd_addr_b = 5;
    #1;
    chk("x5 before reset", 100, da, 32'h1234);
    chk("busy x5 before reset", 100, bv, 32'h20);
    chk("rd_busy_b before reset", 100, {31'b0, bb}, 32'h1);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("x5 async reset", 101, da, 32'h0);
    chk("busy_vec async reset", 101, bv, 32'h0);
    chk("rd_busy_b async reset", 101, {31'b0, bb}, 32'h0);
    @(negedge clock);
    wr_en = 1; wr_addr = 5; wr_data = 32'hAAAA;
    issue_en = 1; issue_addr = 6;
    link_en = 1; link_pc = 32'h500;
    @(negedge clock);
    idle();
    rd_addr_a = 5; rd_addr_b = 31;
    reset_n = 1'b1;
    #2;
    chk("no commit in reset x5", 102, da, 32'h0);
    chk("no commit in reset x31", 102, db, 32'h0);
    chk("no busy in reset", 102, bv, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, got running, expected finished");
    $fatal(1);
  end
endmodule
`default_nettype wire
